// File: rtl/phy_pkg.sv
// Constants and types shared by the lane's serializer and deserializer.
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } rx_state_t;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: bit-hunts for COM, locks after SYNC_COUNT aligned COMs,
// then presents data bytes. Define SP_COM_CNT_EN to add the saturating com_count output.
module serial_paralelo #(
  parameter logic [7:0]  COM_SYMBOL = phy_pkg::COM_SYMBOL,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        in_serial,
  output logic [7:0]  out_parallel,
  output logic        valid_out,
  output logic        active
`ifdef SP_COM_CNT_EN
  ,
  output logic [15:0] com_count
`endif
);
  import phy_pkg::*;

  localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

  rx_state_t  state, state_nxt;
  logic [7:0] shift_reg;
  logic [7:0] window;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] sync_cnt, sync_cnt_nxt;
  logic       boundary_d;
  logic       com_hit;
  logic       at_boundary;

  // window is the byte as it will stand once this edge's bit is shifted in
  assign window      = {shift_reg[6:0], in_serial};
  assign com_hit     = (window == COM_SYMBOL);
  assign at_boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt + 3'd1;
    sync_cnt_nxt = sync_cnt;
    case (state)
      SEARCH: begin
        bit_cnt_nxt = '0;
        if (com_hit) begin
          sync_cnt_nxt = 4'd1;
          state_nxt    = (SYNC_CNT == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (at_boundary) begin
          if (com_hit) begin
            sync_cnt_nxt = sync_cnt + 4'd1;
            if (sync_cnt + 4'd1 == SYNC_CNT) state_nxt = ACTIVE;
          end else begin
            sync_cnt_nxt = '0;
            state_nxt    = SEARCH;
          end
        end
      end
      default: ;
    endcase
  end

  // boundary_d marks the edge after an ACTIVE byte boundary, when shift_reg holds that byte
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      sync_cnt     <= '0;
      boundary_d   <= 1'b0;
      out_parallel <= '0;
      valid_out    <= 1'b0;
      active       <= 1'b0;
    end else begin
      shift_reg  <= window;
      bit_cnt    <= bit_cnt_nxt;
      sync_cnt   <= sync_cnt_nxt;
      boundary_d <= (state == ACTIVE) && at_boundary;
      active     <= (state == ACTIVE);
      if (boundary_d) begin
        valid_out <= (shift_reg != COM_SYMBOL);
        if (shift_reg != COM_SYMBOL) out_parallel <= shift_reg;
      end
    end
  end

`ifdef SP_COM_CNT_EN
  always_ff @(posedge clk_32f) begin
    if (reset)
      com_count <= '0;
    else if (boundary_d && (shift_reg == COM_SYMBOL) && (com_count != 16'hFFFF))
      com_count <= com_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed bit streams, a history-based reference model checked
// every cycle, and literal expectations at key slots.
module tb_serial_paralelo;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         SYNC = 4;

  logic        clk_32f   = 1'b0;
  logic        reset     = 1'b0;
  logic        in_serial = 1'b0;
  logic [7:0]  out_parallel;
  logic        valid_out;
  logic        active;
`ifdef SP_COM_CNT_EN
  logic [15:0] com_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 0;
  bit chk_en = 1;
  bit hist[$];

  serial_paralelo #(.COM_SYMBOL(COM), .SYNC_COUNT(SYNC)) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .in_serial   (in_serial),
    .out_parallel(out_parallel),
    .valid_out   (valid_out),
    .active      (active)
`ifdef SP_COM_CNT_EN
    ,
    .com_count   (com_count)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the bits received since the last reset, interpreted from scratch
  function automatic logic [7:0] byte_at(input int j);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (j - 7 + i >= 0) ? logic'(hist[j - 7 + i]) : 1'b0};
    return b;
  endfunction

  task automatic eval(output logic e_act, output logic e_vld, output logic [7:0] e_op,
                      output int e_cc);
    int t, s, lock_at, j, m;
    logic [7:0] b;
    t = hist.size() - 1;
    s = 0;
    lock_at = -1;
    e_act = 1'b0; e_vld = 1'b0; e_op = '0; e_cc = 0;
    while (lock_at < 0 && s <= t) begin
      j = -1;
      for (int x = s; x <= t; x++) begin
        if (byte_at(x) == COM) begin
          j = x;
          break;
        end
      end
      if (j < 0) break;
      m = 1;
      while (m < SYNC && j + 8*m <= t && byte_at(j + 8*m) == COM) m++;
      if (m == SYNC)          lock_at = j + 8*(SYNC - 1);
      else if (j + 8*m <= t)  s = j + 8*m + 1;
      else                    break;
    end
    if (lock_at >= 0) begin
      e_act = (t >= lock_at + 1);
      for (int bd = lock_at + 8; bd <= t - 1; bd += 8) begin
        b = byte_at(bd);
        if (b == COM) begin
          e_vld = 1'b0;
          if (e_cc < 65535) e_cc++;
        end else begin
          e_vld = 1'b1;
          e_op  = b;
        end
      end
    end
  endtask

  always @(posedge clk_32f) begin
    if (reset) begin
      hist.delete();
      armed = 1;
    end else if (armed) begin
      hist.push_back(in_serial);
    end
  end

  always @(negedge clk_32f) begin
    logic       e_act, e_vld;
    logic [7:0] e_op;
    int         e_cc;
    if (armed && chk_en) begin
      eval(e_act, e_vld, e_op, e_cc);
      check("model active",       active,       e_act);
      check("model valid_out",    valid_out,    e_vld);
      check("model out_parallel", out_parallel, e_op);
`ifdef SP_COM_CNT_EN
      check("model com_count",    com_count,    e_cc);
`endif
    end
  end

  task automatic send_bit(input logic b);
    in_serial = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 7, 0);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) begin
      in_serial = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic lock_seq();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (SYNC) send_byte(COM);
  endtask

  initial begin
    logic [7:0] rb;
    @(posedge clk_32f);
    #1;

    // 1: reset
    do_reset(3);
    check("reset out_parallel", out_parallel, 8'h00);
    check("reset valid_out",    valid_out,    1'b0);
    check("reset active",       active,       1'b0);

    // 2/3: lock, then A5, 3C, COM, COM
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (SYNC) send_byte(COM);
    check("active at 4th COM LSB", active, 1'b0);
    send_bit(1'b1);
    check("active one cycle later", active, 1'b1);
    check("valid_out idle after lock", valid_out, 1'b0);
    send_bits(8'hA5, 6, 0);
    check("valid_out before A5 update", valid_out, 1'b0);
    send_byte(8'h3C);
    check("A5 out_parallel", out_parallel, 8'hA5);
    check("A5 valid_out",    valid_out,    1'b1);
    send_byte(COM);
    check("3C out_parallel", out_parallel, 8'h3C);
    check("3C valid_out",    valid_out,    1'b1);
    send_byte(COM);
    check("COM valid_out",   valid_out,    1'b0);
    check("COM holds out",   out_parallel, 8'h3C);

    // 4: broken lock and fresh relock
    do_reset(1);
    send_byte(COM); send_byte(COM); send_byte(8'h00);
    check("broken lock active", active, 1'b0);
    repeat (3) send_byte(COM);
    send_bit(1'b1);
    check("three COMs not enough", active, 1'b0);
    send_bits(COM, 6, 0);
    send_byte(COM);
    check("relock active", active, 1'b1);

    // 5: reset in the middle of a data byte
    send_byte(8'h5A);
    send_bits(8'h77, 7, 5);
    check("5A out_parallel", out_parallel, 8'h5A);
    check("5A valid_out",    valid_out,    1'b1);
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
    check("mid reset out_parallel", out_parallel, 8'h00);
    check("mid reset valid_out",    valid_out,    1'b0);
    check("mid reset active",       active,       1'b0);
    send_bits(8'h77, 4, 0);
    send_byte(8'h12);
    check("no lock after reset", active, 1'b0);
    check("no byte after reset", valid_out, 1'b0);
    lock_seq();
    send_byte(8'h81);
    send_bit(1'b1);
    check("81 out_parallel", out_parallel, 8'h81);
    check("81 valid_out",    valid_out,    1'b1);
    send_bits(COM, 6, 0);

    // random idle/data stream, checked by the model
    for (int k = 0; k < 40; k++) begin
      rb = ($urandom_range(0, 1) == 0) ? COM : 8'($urandom_range(0, 255));
      send_byte(rb);
    end
    send_byte(COM);
    send_byte(COM);

`ifdef SP_COM_CNT_EN
    // 6: COM counter and saturation
    do_reset(1);
    lock_seq();
    repeat (5) send_byte(COM);
    send_bit(1'b1);
    check("com_count five", com_count, 16'd5);
    chk_en = 0;
    force dut.com_count = 16'hFFFF;
    send_bit(1'b0);
    release dut.com_count;
    send_bits(COM, 5, 0);
    send_bit(1'b1);
    check("com_count saturates", com_count, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
